// File: rtl/stdp_pkg.sv
// stdp_pkg: shared FSM type and fixed-point helpers for the STDP engine
package stdp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  function automatic logic signed [127:0] fx_mul(input logic signed [63:0] a, input logic signed [63:0] b, input int q);
    logic signed [127:0] p;
    p = 128'(a) * 128'(b);
    return p >>> q;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] mx);
    return v >= mx ? mx : v + 32'd1;
  endfunction
endpackage

// File: rtl/stdp_kernel.sv
// stdp_kernel: two-stage piecewise-linear STDP kernel with rate scaling and weight clamp
module stdp_kernel import stdp_pkg::*; #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int T_W = 8,
  parameter int AW = 3
) (
  input logic clk,
  input logic reset,
  input logic in_valid,
  input logic [AW-1:0] in_idx,
  input logic [T_W-1:0] in_age,
  input logic in_pot,
  input logic in_dep,
  input logic signed [N-1:0] in_w,
  input logic signed [N-1:0] a_plus,
  input logic signed [N-1:0] a_minus,
  input logic signed [N-1:0] m1,
  input logic signed [N-1:0] b1,
  input logic signed [N-1:0] m2,
  input logic signed [N-1:0] b2,
  input logic [T_W-1:0] t_break,
  input logic signed [N-1:0] w_min,
  input logic signed [N-1:0] w_max,
  output logic out_valid,
  output logic [AW-1:0] out_idx,
  output logic signed [N-1:0] out_w
);
  logic v_q, v_d, pot_q, pot_d, dep_q, dep_d, seg;
  logic [AW-1:0] idx_q, idx_d;
  logic signed [N-1:0] w_q, w_d, k_q, k_d, age_fx, kr, p, dw;
  logic signed [N:0] s, lo, hi;
  always_comb begin
    seg = in_age < t_break;
    age_fx = N'(in_age) << Q;
    kr = N'(fx_mul(64'(seg ? m1 : m2), 64'(age_fx), Q)) + (seg ? b1 : b2);
    k_d = kr[N-1] ? '0 : kr;
    v_d = in_valid;
    idx_d = in_idx;
    pot_d = in_valid && in_pot;
    dep_d = in_valid && in_dep;
    w_d = in_w;
  end
  always_ff @(posedge clk)
    if (reset) begin
      v_q <= 1'b0;
      idx_q <= '0;
      pot_q <= 1'b0;
      dep_q <= 1'b0;
      w_q <= '0;
      k_q <= '0;
    end else begin
      v_q <= v_d;
      idx_q <= idx_d;
      pot_q <= pot_d;
      dep_q <= dep_d;
      w_q <= w_d;
      k_q <= k_d;
    end
  always_comb begin
    p = N'(fx_mul(64'(pot_q ? a_plus : a_minus), 64'(k_q), Q));
    dw = pot_q ? p : dep_q ? -p : '0;
    s = (N+1)'(w_q) + (N+1)'(dw);
    lo = (N+1)'(w_min);
    hi = (N+1)'(w_max);
    out_w = s < lo ? w_min : s > hi ? w_max : s[N-1:0];
    out_valid = v_q;
    out_idx = idx_q;
  end
endmodule

// File: rtl/stdp_array.sv
// stdp_array: multi-synapse STDP engine walking synapses through a shared kernel pipeline
module stdp_array import stdp_pkg::*; #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int NUM_SYN = 8,
  parameter int T_W = 8,
  parameter int AW = NUM_SYN > 1 ? $clog2(NUM_SYN) : 1
) (
  input logic clk,
  input logic reset,
  input logic tick,
  input logic [NUM_SYN-1:0] pre_spike,
  input logic post_spike,
  input logic signed [N-1:0] a_plus,
  input logic signed [N-1:0] a_minus,
  input logic signed [N-1:0] m1,
  input logic signed [N-1:0] b1,
  input logic signed [N-1:0] m2,
  input logic signed [N-1:0] b2,
  input logic [T_W-1:0] t_break,
  input logic signed [N-1:0] w_min,
  input logic signed [N-1:0] w_max,
  input logic wr_en,
  input logic [AW-1:0] wr_addr,
  input logic signed [N-1:0] wr_data,
  input logic [AW-1:0] rd_addr,
  output logic signed [N-1:0] rd_data,
  output logic busy,
  output logic done,
  output logic tick_overrun
);
  localparam logic [AW-1:0] LAST = AW'(NUM_SYN - 1);
  localparam logic [31:0] AGE_MAX = 32'({T_W{1'b1}});
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, k_idx;
  logic drain_q, drain_d, ovr_q, ovr_d;
  logic signed [N-1:0] w_q [NUM_SYN];
  logic signed [N-1:0] w_d [NUM_SYN];
  logic [T_W-1:0] age_pre_q [NUM_SYN];
  logic [T_W-1:0] age_pre_d [NUM_SYN];
  logic [T_W-1:0] age_post_q, age_post_d;
  logic [NUM_SYN-1:0] pre_valid_q, pre_valid_d, pre_lat_q, pre_lat_d;
  logic post_valid_q, post_valid_d, post_lat_q, post_lat_d;
  logic signed [N-1:0] rd_data_q, rd_data_d, k_w;
  logic accept, issue, pot, dep, k_valid;
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb
    state_d = state_q == IDLE ? (tick ? SCAN : IDLE) :
              state_q == SCAN ? (idx_q == LAST ? DRAIN : SCAN) :
              state_q == DRAIN ? (drain_q ? DONE : DRAIN) : IDLE;
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    issue = state_q == SCAN;
    accept = state_q == IDLE && tick;
    tick_overrun = ovr_q;
    rd_data = rd_data_q;
  end
  always_comb begin
    pot = post_lat_q && pre_valid_q[idx_q];
    dep = pre_lat_q[idx_q] && post_valid_q && !post_lat_q;
  end
  stdp_kernel #(.N(N), .Q(Q), .T_W(T_W), .AW(AW)) u_kernel (
    .clk(clk),
    .reset(reset),
    .in_valid(issue),
    .in_idx(idx_q),
    .in_age(pot ? age_pre_q[idx_q] : age_post_q),
    .in_pot(pot),
    .in_dep(dep),
    .in_w(w_q[idx_q]),
    .a_plus(a_plus),
    .a_minus(a_minus),
    .m1(m1),
    .b1(b1),
    .m2(m2),
    .b2(b2),
    .t_break(t_break),
    .w_min(w_min),
    .w_max(w_max),
    .out_valid(k_valid),
    .out_idx(k_idx),
    .out_w(k_w)
  );
  always_comb begin
    idx_d = issue ? idx_q + AW'(1) : '0;
    drain_d = state_q == DRAIN && !drain_q;
    w_d = w_q;
    age_pre_d = age_pre_q;
    age_post_d = age_post_q;
    pre_valid_d = pre_valid_q;
    post_valid_d = post_valid_q;
    pre_lat_d = accept ? pre_spike : pre_lat_q;
    post_lat_d = accept ? post_spike : post_lat_q;
    if (accept) begin
      for (int i = 0; i < NUM_SYN; i++)
        age_pre_d[i] = pre_spike[i] ? '0 : T_W'(sat_inc(32'(age_pre_q[i]), AGE_MAX));
      age_post_d = post_spike ? '0 : T_W'(sat_inc(32'(age_post_q), AGE_MAX));
      pre_valid_d = pre_valid_q | pre_spike;
      post_valid_d = post_valid_q | post_spike;
    end
    if (state_q == IDLE && wr_en && 32'(wr_addr) < NUM_SYN)
      w_d[wr_addr] = wr_data;
    if (k_valid)
      w_d[k_idx] = k_w;
    rd_data_d = 32'(rd_addr) < NUM_SYN ? w_q[rd_addr] : '0;
    ovr_d = busy && tick;
  end
  always_ff @(posedge clk)
    if (reset) begin
      idx_q <= '0;
      drain_q <= 1'b0;
      w_q <= '{default: '0};
      age_pre_q <= '{default: '0};
      age_post_q <= '0;
      pre_valid_q <= '0;
      post_valid_q <= 1'b0;
      pre_lat_q <= '0;
      post_lat_q <= 1'b0;
      rd_data_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      drain_q <= drain_d;
      w_q <= w_d;
      age_pre_q <= age_pre_d;
      age_post_q <= age_post_d;
      pre_valid_q <= pre_valid_d;
      post_valid_q <= post_valid_d;
      pre_lat_q <= pre_lat_d;
      post_lat_q <= post_lat_d;
      rd_data_q <= rd_data_d;
      ovr_q <= ovr_d;
    end
endmodule

// File: tb/tb_stdp_array.sv
// tb_stdp_array: table-driven self-checking bench for stdp_array
module tb_stdp_array;
  typedef enum logic [2:0] {OP_RST, OP_WR, OP_TICK, OP_RD, OP_TB, OP_B2} op_t;
  typedef struct {
    op_t op;
    logic [3:0] pre;
    logic post;
    logic [1:0] addr;
    logic [31:0] data;
  } step_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic post_spike = 1'b0;
  logic wr_en = 1'b0;
  logic busy, done, tick_overrun;
  logic [3:0] pre_spike = '0;
  logic signed [31:0] a_plus = 32'h8000;
  logic signed [31:0] a_minus = 32'h8000;
  logic signed [31:0] m1 = 32'hFFFFC000;
  logic signed [31:0] b1 = 32'h10000;
  logic signed [31:0] m2 = '0;
  logic signed [31:0] b2 = '0;
  logic signed [31:0] w_min = '0;
  logic signed [31:0] w_max = 32'h10000;
  logic signed [31:0] wr_data = '0;
  logic signed [31:0] rd_data;
  logic [7:0] t_break = 8'd4;
  logic [1:0] wr_addr = '0;
  logic [1:0] rd_addr = '0;
  int checks = 0;
  int errors = 0;
  step_t steps[$];
  always #5 clk = ~clk;
  stdp_array #(.N(32), .Q(16), .NUM_SYN(4), .T_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .pre_spike(pre_spike),
    .post_spike(post_spike),
    .a_plus(a_plus),
    .a_minus(a_minus),
    .m1(m1),
    .b1(b1),
    .m2(m2),
    .b2(b2),
    .t_break(t_break),
    .w_min(w_min),
    .w_max(w_max),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .tick_overrun(tick_overrun)
  );
  function automatic step_t mk(op_t op, logic [3:0] pre, logic post, logic [1:0] addr, logic [31:0] data);
    step_t s;
    s.op = op;
    s.pre = pre;
    s.post = post;
    s.addr = addr;
    s.data = data;
    return s;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(tick_overrun), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
  endtask
  task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic do_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(nm, rd_data, exp);
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic do_tick(input logic [3:0] pre, input logic post);
    int n;
    tick = 1'b1;
    pre_spike = pre;
    post_spike = post;
    @(negedge clk);
    tick = 1'b0;
    pre_spike = '0;
    post_spike = 1'b0;
    chk("tick_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("done_latency", 32'(n), 32'd7);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask
  initial begin
    int n;
    steps.push_back(mk(OP_RST, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd0, 32'h8000));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd1, 32'h1234));
    steps.push_back(mk(OP_TICK, 4'h1, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b1, 2'd0, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd0, 32'hC000));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd1, 32'h1234));
    steps.push_back(mk(OP_RST, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd1, 32'h8000));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd3, 32'h1000));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b1, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'hA, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd1, 32'h2000));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd3, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_RST, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd2, 32'hC000));
    steps.push_back(mk(OP_TICK, 4'h4, 1'b1, 2'd0, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd2, 32'h10000));
    steps.push_back(mk(OP_RST, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd0, 32'h4000));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd3, 32'h4000));
    steps.push_back(mk(OP_TICK, 4'h8, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h1, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b1, 2'd0, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd0, 32'h6000));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd3, 32'h4000));
    steps.push_back(mk(OP_RST, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TB, 4'h0, 1'b0, 2'd0, 32'd8));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd0, 32'h8000));
    steps.push_back(mk(OP_TICK, 4'h1, 1'b0, 2'd0, 32'h0));
    for (int i = 0; i < 5; i++)
      steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b1, 2'd0, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd0, 32'h8000));
    steps.push_back(mk(OP_TB, 4'h0, 1'b0, 2'd0, 32'd4));
    steps.push_back(mk(OP_RST, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_B2, 4'h0, 1'b0, 2'd0, 32'h4000));
    steps.push_back(mk(OP_WR, 4'h0, 1'b0, 2'd0, 32'h8000));
    steps.push_back(mk(OP_TICK, 4'h1, 1'b0, 2'd0, 32'h0));
    for (int i = 0; i < 3; i++)
      steps.push_back(mk(OP_TICK, 4'h0, 1'b0, 2'd0, 32'h0));
    steps.push_back(mk(OP_TICK, 4'h0, 1'b1, 2'd0, 32'h0));
    steps.push_back(mk(OP_RD, 4'h0, 1'b0, 2'd0, 32'hA000));
    steps.push_back(mk(OP_B2, 4'h0, 1'b0, 2'd0, 32'h0));
    @(negedge clk);
    foreach (steps[k]) begin
      case (steps[k].op)
        OP_RST: do_reset();
        OP_WR: do_wr(steps[k].addr, steps[k].data);
        OP_TICK: do_tick(steps[k].pre, steps[k].post);
        OP_RD: do_rd($sformatf("step%0d_w%0d", k, steps[k].addr), steps[k].addr, steps[k].data);
        OP_TB: t_break = steps[k].data[7:0];
        OP_B2: b2 = steps[k].data;
        default: ;
      endcase
    end
    do_reset();
    do_wr(2'd0, 32'h8000);
    tick = 1'b1;
    pre_spike = 4'h1;
    @(negedge clk);
    tick = 1'b0;
    pre_spike = '0;
    chk("ovr_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    tick = 1'b1;
    post_spike = 1'b1;
    wr_en = 1'b1;
    wr_addr = 2'd2;
    wr_data = 32'h7777;
    @(negedge clk);
    tick = 1'b0;
    post_spike = 1'b0;
    wr_en = 1'b0;
    chk("ovr_pulse", 32'(tick_overrun), 32'd1);
    @(negedge clk);
    chk("ovr_pulse_end", 32'(tick_overrun), 32'd0);
    wait_done(n);
    chk("ovr_done_latency", 32'(n), 32'd4);
    @(negedge clk);
    do_rd("ovr_w0", 2'd0, 32'h8000);
    do_rd("busy_wr_ignored", 2'd2, 32'h0);
    do_tick(4'h0, 1'b1);
    do_rd("ovr_age_intact", 2'd0, 32'hE000);
    do_wr(2'd1, 32'h5555);
    rd_addr = 2'd1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("scan_rd_w1", rd_data, 32'h5555);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_overrun", 32'(tick_overrun), 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    chk("midrst_stays_idle", 32'(busy), 32'd0);
    do_rd("midrst_w0", 2'd0, 32'h0);
    do_rd("midrst_w1", 2'd1, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stdp_array.md
# stdp_array

Multi-synapse spike-timing-dependent plasticity engine. Holds NUM_SYN synaptic weights with per-synapse pre-spike ages and one post-spike age. On each simulation tick it walks the synapses through a shared piecewise-linear kernel pipeline and applies clamped potentiation or depression. Sits beside the izhikevich neuron core: the core drives `post_spike`, the presynaptic fabric drives `pre_spike`, and the downstream current summation reads weights.

## Interface

- N, 32, fixed-point word width (signed)
- Q, 16, fractional bits
- NUM_SYN, 8, synapse count (≥1)
- T_W, 8, age counter width (ticks)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  timestep strobe; accepted only when `busy`=0
- pre_spike  in  NUM_SYN  presynaptic spikes this tick
- post_spike  in  1  postsynaptic spike this tick
- a_plus, a_minus  in  N  learning rates (positive)
- m1, b1, m2, b2  in  N  kernel slopes/intercepts, segments 1/2
- t_break  in  T_W  segment breakpoint (ticks)
- w_min, w_max  in  N  weight clamp bounds
- wr_en, wr_addr [$clog2(NUM_SYN)], wr_data [N]  in  weight preload port
- rd_addr  in  $clog2(NUM_SYN)  weight read address
- rd_data  out  N  registered weight read
- busy  out  1  update in progress
- done  out  1  one-cycle pulse at end of update
- tick_overrun  out  1  one-cycle pulse when tick arrives while busy

## Operation

- Reset: all weights 0, ages 0, all valid bits 0, FSM IDLE; `rd_data`, `busy`, `done`, `tick_overrun` = 0.
- States: IDLE → SCAN (tick accepted) → DRAIN (after last synapse issued) → DONE (pipeline empty) → IDLE.
- On tick accept: latch `pre_spike`/`post_spike`; every age increments saturating at 2^T_W−1; spiking synapses (and post if spiking) set age 0, valid 1.
- SCAN issues synapse i = 0..NUM_SYN−1, one per cycle, into `stdp_kernel`.
- Potentiation: `post_spike` latched and pre_valid[i] → dw = a_plus·k(age_pre[i]).
- Depression: pre_spike[i] latched, post_valid, `post_spike` not latched → dw = −a_minus·k(age_post).
- Simultaneous pre/post same tick: age 0, potentiation only (t_change = 0 treated as non-negative).
- Neither condition → dw = 0; weight rewritten unchanged.
- Kernel: age_fx = age << Q; k = m1·age_fx + b1 if age < t_break else m2·age_fx + b2; negative k clamps to 0.
- Fixed-point multiply: full 2N signed product, arithmetic shift right Q, truncate to N. Weight sum computed at N+1 bits, clamped to [w_min, w_max].
- Weight preload: `wr_en` honoured only in IDLE; ignored while busy.
- `rd_data` = weight[rd_addr] one cycle after address; reads during SCAN may return old or new value per synapse.
- Reset mid-update: abandon scan immediately, all state to reset values.

## Timing

- Tick sampled at edge 0 → SCAN edges 1..NUM_SYN → DRAIN 2 cycles → `done` high in cycle NUM_SYN+3.
- `busy` high cycles 1 through NUM_SYN+3 inclusive; next tick accepted in cycle NUM_SYN+4.
- Kernel pipeline: 2 stages (kernel evaluate, scale+clamp+write).
- Tick while busy: ignored, `tick_overrun` pulses the following cycle, spikes of that tick discarded.

## Structure

- Package `stdp_pkg`: FSM state enum, `fx_mul` function (N, Q), saturating-add helper.
- Sub-module `stdp_kernel`: 2-stage piecewise-linear kernel, scaling and clamp; one instance shared across synapses.

## Test plan

Defaults Q=16, NUM_SYN=4; m1=0xFFFFC000 (−0.25), b1=0x00010000, m2=b2=0, t_break=4, a_plus=a_minus=0x8000, w_min=0, w_max=0x00010000.

- Preload w0=0x8000; pre[0] at tick 0, post at tick 2 → age 2, k=0.5, w0=0xC000; other weights unchanged.
- w1=0x8000; post at tick 0, pre[1] at tick 1 → k=0.75, dw=−0x6000, w1=0x2000.
- pre[2]+post same tick, w2=0xC000 → dw=+0x8000, clamped w2=0x00010000.
- pre[3] tick 0, post tick 6 (≥ t_break) → k=0, w3 unchanged; `done` exactly NUM_SYN+3 cycles after tick.
- Tick at cycle 2 of busy → `tick_overrun` pulse, no weight change from it; reset asserted mid-SCAN → all outputs and weights 0 next cycle.
